// File: rtl/wb_stage.sv
// wb_stage: write-back stage with load extraction, bypass buses, RF write port,
// misaligned-load flag and retired-instruction counter.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_we,
    input  logic [4:0]       mem_waddr,
    input  logic [31:0]      mem_result,
    input  logic [2:0]       mem_load_op,
    input  logic [31:0]      mem_rdata,
    output logic [37:0]      mem_to_id_bus,
    output logic [37:0]      wb_to_id_bus,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             adel,
    output logic [31:0]      debug_wb_pc,
    output logic [CNT_W-1:0] instret
);
    logic [1:0]       w_off;
    logic [7:0]       w_b;
    logic [15:0]      w_h;
    logic [31:0]      w_data;
    logic             w_mis;
    logic             w_we;
    logic             r_valid;
    logic [31:0]      r_pc;
    logic             r_we;
    logic [4:0]       r_waddr;
    logic [31:0]      r_data;
    logic             r_mis;
    logic             r_fresh;
    logic [CNT_W-1:0] r_instret;

    assign w_off = mem_result[1:0];
    assign w_b   = mem_rdata[{w_off, 3'b000} +: 8];
    assign w_h   = mem_rdata[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_data = (mem_load_op == 3'b001) ? {{24{w_b[7]}}, w_b} :
                 (mem_load_op == 3'b010) ? {24'b0, w_b} :
                 (mem_load_op == 3'b011) ? {{16{w_h[15]}}, w_h} :
                 (mem_load_op == 3'b100) ? {16'b0, w_h} :
                 (mem_load_op == 3'b101) ? mem_rdata : mem_result;
        w_mis  = ((mem_load_op == 3'b011 || mem_load_op == 3'b100) && w_off[0]) ||
                 (mem_load_op == 3'b101 && w_off != 2'b00);
    end

    assign w_we          = mem_valid & mem_we & ~w_mis & (mem_waddr != 5'd0);
    assign mem_to_id_bus = {w_we, mem_waddr, w_data};

    // fresh marks the first cycle an instruction sits in WB, so a stalled
    // instruction writes, retires and raises adel only once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_we      <= 1'b0;
            r_waddr   <= 5'd0;
            r_data    <= 32'd0;
            r_mis     <= 1'b0;
            r_fresh   <= 1'b0;
            r_instret <= '0;
        end else begin
            if (r_valid && r_fresh)
                r_instret <= r_instret + CNT_W'(1);
            if (flush) begin
                r_valid <= 1'b0;
                r_we    <= 1'b0;
                r_fresh <= 1'b1;
            end else if (stall) begin
                r_fresh <= 1'b0;
            end else begin
                r_valid <= mem_valid;
                r_pc    <= mem_pc;
                r_we    <= w_we;
                r_waddr <= mem_waddr;
                r_data  <= w_data;
                r_mis   <= w_mis;
                r_fresh <= 1'b1;
            end
        end
    end

    assign rf_we        = r_valid & r_we & r_fresh;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_data;
    assign wb_to_id_bus = {r_valid & r_we, r_waddr, r_data};
    assign adel         = r_valid & r_mis & r_fresh;
    assign debug_wb_pc  = r_pc;
    assign instret      = r_instret;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage.
module tb_wb_stage;
    logic        clk = 0, resetn = 0, stall = 0, flush = 0;
    logic        mem_valid = 0, mem_we = 0;
    logic [31:0] mem_pc = 0, mem_result = 0, mem_rdata = 0;
    logic [4:0]  mem_waddr = 0;
    logic [2:0]  mem_load_op = 0;
    logic [37:0] mem_to_id_bus, wb_to_id_bus;
    logic        rf_we, adel;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc, instret;

    wb_stage dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_result(mem_result), .mem_load_op(mem_load_op),
        .mem_rdata(mem_rdata), .mem_to_id_bus(mem_to_id_bus), .wb_to_id_bus(wb_to_id_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .adel(adel),
        .debug_wb_pc(debug_wb_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d;
        logic        mis;
        logic        fresh;
        logic [31:0] cnt;
    } st_t;

    st_t m;
    st_t q[$];

    task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] res, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (res[1:0])
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = res[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'd1: return {{24{b[7]}}, b};
            3'd2: return {24'h0, b};
            3'd3: return {{16{h[15]}}, h};
            3'd4: return {16'h0, h};
            3'd5: return rd;
            default: return res;
        endcase
    endfunction

    function automatic logic misal(input logic [2:0] op, input logic [31:0] res);
        return ((op == 3'd3 || op == 3'd4) && res[0]) || (op == 3'd5 && res[1:0] != 2'd0);
    endfunction

    task automatic model_reset();
        m = '{v: 1'b0, pc: 32'hBFC0_0000, we: 1'b0, wa: 5'd0, d: 32'd0, mis: 1'b0, fresh: 1'b0, cnt: 32'd0};
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] res, input logic [2:0] op, input logic [31:0] rd,
                         input logic st, input logic fl);
        logic [31:0] d;
        logic        mi, bwe;
        st_t         e;
        mem_valid = v; mem_pc = pc; mem_we = we; mem_waddr = wa;
        mem_result = res; mem_load_op = op; mem_rdata = rd; stall = st; flush = fl;
        d   = ext(op, res, rd);
        mi  = misal(op, res);
        bwe = v && we && !mi && wa != 5'd0;
        #1;
        chk("mem_to_id_bus", mem_to_id_bus, {bwe, wa, d});
        if (m.v && m.fresh) m.cnt++;
        if (fl) begin
            m.v = 1'b0; m.we = 1'b0; m.fresh = 1'b1;
        end else if (st) begin
            m.fresh = 1'b0;
        end else begin
            m.v = v; m.pc = pc; m.we = bwe; m.wa = wa; m.d = d; m.mis = mi; m.fresh = 1'b1;
        end
        q.push_back(m);
        @(posedge clk); #1;
        e = q.pop_front();
        chk("rf_we", 38'(rf_we), 38'(e.v & e.we & e.fresh));
        chk("wb_bus_we", 38'(wb_to_id_bus[37]), 38'(e.v & e.we));
        chk("adel", 38'(adel), 38'(e.v & e.mis & e.fresh));
        chk("instret", 38'(instret), 38'(e.cnt));
        if (e.v) begin
            chk("rf_waddr", 38'(rf_waddr), 38'(e.wa));
            chk("rf_wdata", 38'(rf_wdata), 38'(e.d));
            chk("wb_to_id_bus", wb_to_id_bus, {e.we, e.wa, e.d});
            chk("debug_wb_pc", 38'(debug_wb_pc), 38'(e.pc));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rf_we"}, 38'(rf_we), 38'd0);
        chk({tag, "_rf_waddr"}, 38'(rf_waddr), 38'd0);
        chk({tag, "_rf_wdata"}, 38'(rf_wdata), 38'd0);
        chk({tag, "_wb_bus"}, wb_to_id_bus, 38'd0);
        chk({tag, "_adel"}, 38'(adel), 38'd0);
        chk({tag, "_pc"}, 38'(debug_wb_pc), 38'(32'hBFC0_0000));
        chk({tag, "_instret"}, 38'(instret), 38'd0);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        chk_reset("por");
        resetn = 1;
        // byte loads: off=2 selects 0xFF
        cycle(1, 32'h100, 1, 5'd3, 32'h0000_1002, 3'd1, 32'h80FF_7F01, 0, 0);
        cycle(1, 32'h104, 1, 5'd4, 32'h0000_1002, 3'd2, 32'h80FF_7F01, 0, 0);
        cycle(1, 32'h108, 1, 5'd6, 32'h0000_1003, 3'd1, 32'h80FF_7F01, 0, 0);
        cycle(1, 32'h10C, 1, 5'd6, 32'h0000_1000, 3'd1, 32'h80FF_7F81, 0, 0);
        // halfwords, word, then misaligned lw
        cycle(1, 32'h110, 1, 5'd7, 32'h0000_2002, 3'd3, 32'h8001_1234, 0, 0);
        cycle(1, 32'h114, 1, 5'd8, 32'h0000_2002, 3'd4, 32'h8001_1234, 0, 0);
        cycle(1, 32'h118, 1, 5'd9, 32'h0000_2000, 3'd3, 32'h8001_F234, 0, 0);
        cycle(1, 32'h11C, 1, 5'd10, 32'h0000_2000, 3'd5, 32'hCAFE_F00D, 0, 0);
        cycle(1, 32'h120, 1, 5'd11, 32'h0000_2001, 3'd5, 32'hCAFE_F00D, 0, 0);
        cycle(1, 32'h124, 1, 5'd12, 32'h0000_2003, 3'd4, 32'hCAFE_F00D, 0, 0);
        cycle(1, 32'h128, 1, 5'd13, 32'h0000_3000, 3'd6, 32'hCAFE_F00D, 0, 0);
        // stall hold
        cycle(1, 32'h130, 1, 5'd5, 32'h0000_1234, 3'd0, 32'h0, 0, 0);
        cycle(1, 32'h134, 1, 5'd7, 32'h0000_9999, 3'd0, 32'h0, 1, 0);
        cycle(1, 32'h134, 1, 5'd7, 32'h0000_9999, 3'd0, 32'h0, 1, 0);
        cycle(1, 32'h134, 1, 5'd7, 32'h0000_9999, 3'd0, 32'h0, 1, 0);
        // flush has priority over stall
        cycle(1, 32'h134, 1, 5'd7, 32'h0000_9999, 3'd0, 32'h0, 1, 1);
        cycle(0, 32'h138, 1, 5'd7, 32'h0000_5555, 3'd0, 32'h0, 0, 0);
        // $0 guard
        cycle(1, 32'h13C, 1, 5'd0, 32'hDEAD_BEEF, 3'd0, 32'h0, 0, 0);
        cycle(1, 32'h140, 0, 5'd9, 32'h0000_0042, 3'd0, 32'h0, 0, 0);
        cycle(1, 32'h144, 1, 5'd14, 32'h0000_0077, 3'd0, 32'h0, 0, 0);
        // async reset while rf_we is high
        resetn = 0;
        #1;
        chk_reset("async");
        model_reset();
        @(posedge clk); #1;
        chk_reset("held");
        resetn = 1;
        cycle(1, 32'h200, 1, 5'd15, 32'h0000_ABCD, 3'd0, 32'h0, 0, 0);
        cycle(1, 32'h204, 1, 5'd16, 32'h0000_1001, 3'd2, 32'h1234_5678, 0, 0);
        cycle(0, 32'h208, 0, 5'd0, 32'h0, 3'd0, 32'h0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage: the producer end of the register-file forwarding and write interface.
- Takes the MEM-stage result and extracts/sign-extends load data.
- Drives the combinational mem_to_id_bus bypass, registers the instruction into WB, then drives the register-file write port and the registered wb_to_id_bus.
- Also maintains a retired-instruction counter and flags misaligned loads.

Parameters:
- RESET_PC, 32'hBFC0_0000, value of debug_wb_pc after reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock (all state updates on rising edge)
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  hold WB register contents (from hazard unit)
- flush  in  1  load a bubble into WB; has priority over stall
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of MEM instruction
- mem_we  in  1  instruction writes a GPR
- mem_waddr  in  5  destination GPR
- mem_result  in  32  ALU result; also the load address for loads
- mem_load_op  in  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; others behave as none
- mem_rdata  in  32  data-RAM read word, valid in the same cycle as the MEM inputs
- mem_to_id_bus  out  38  {we[37], waddr[36:32], data[31:0]}, combinational
- wb_to_id_bus  out  38  {we, waddr, data}, registered
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- adel  out  1  one-cycle pulse: misaligned load retired in WB
- debug_wb_pc  out  32  PC of the WB instruction
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Load extraction (combinational), using off = mem_result[1:0]:
  - lb/lbu select byte mem_rdata[8*off+7 : 8*off]; lb sign-extends, lbu zero-extends.
  - lh/lhu select half mem_rdata[16*off[1]+15 : 16*off[1]].
  - lw passes the word through.
  - none passes mem_result.
- Misaligned: lh/lhu with off[0]=1, or lw with off!=0. The instruction's effective we is then 0 and mis=1.
- mem_to_id_bus.we = mem_valid & mem_we & ~mis & (mem_waddr!=0); data is the extracted value. No clock dependency.
- WB register captures {valid, pc, we_eff, waddr, data, mis} on each rising edge:
  - flush=1: valid<=0 and we<=0; other fields are don't-care; fresh<=1.
  - else stall=1: all fields hold; fresh<=0.
  - else: capture MEM values; fresh<=1.
- rf_we = wb_valid & wb_we & fresh. The write happens exactly once per instruction, even if WB is stalled for many cycles. rf_waddr and rf_wdata always reflect the WB register.
- wb_to_id_bus = {wb_valid & wb_we, wb_waddr, wb_data}. It stays asserted through a stall, since the value is still correct.
- adel = wb_valid & wb_mis & fresh.
- instret increments by 1 when wb_valid & fresh. It wraps from all-ones to 0 with no flag.
- A waddr of 0 never produces we=1 on any output.
- Reset (async, any time including mid-stall): wb_valid=0, wb_we=0, waddr=0, data=0, mis=0, fresh=0, debug_wb_pc=RESET_PC, instret=0. All outputs read zero except debug_wb_pc. The first edge after resetn rises is a normal capture.
- Latency: MEM to rf_we is 1 cycle; mem_to_id_bus is 0 cycles.

Test Plan:
- lb sign/zero: mem_rdata=32'h80FF_7F01, result=...02, op lb → bus data 32'hFFFF_FFFF; op lbu → 32'h0000_00FF. The next cycle gives rf_we=1 with the same data.
- Halfword and misaligned: op lh, off=2, rdata=32'h8001_1234 → 32'hFFFF_8001. Op lw with off=1 → mem_to_id_bus.we=0, then next cycle rf_we=0, adel=1 for exactly 1 cycle, instret+1.
- Stall hold: capture add to $5=32'h1234, then stall for 3 cycles → rf_we high only in the first cycle, wb_to_id_bus.we high for all 4 cycles, instret +1 only.
- Flush over stall: stall=1 and flush=1 together → next cycle wb_valid=0, rf_we=0, wb_to_id_bus.we=0, instret unchanged.
- $0 guard: mem_we=1, waddr=0, data=32'hDEAD_BEEF → both buses show we=0 and rf_we=0; instret still increments.
- Async reset mid-operation: drop resetn between edges while rf_we=1 → all outputs clear immediately, debug_wb_pc=32'hBFC0_0000, and instret=0 without waiting for a clock edge.
